// File: rtl/mapache64_pkg.sv
// Shared mapache64 types plus the loader's command bytes and state encodings.
package mapache64;

  typedef logic [15:0] address_t;
  typedef logic [7:0]  data_t;

  localparam data_t LOADER_CMD_WRITE = 8'h57;
  localparam data_t LOADER_CMD_HOLD  = 8'h48;
  localparam data_t LOADER_CMD_GO    = 8'h47;

  typedef enum logic [2:0] {
    P_IDLE,
    P_ADDR_HI,
    P_ADDR_LO,
    P_LEN,
    P_DATA,
    P_WRITE
  } parse_state_t;

  typedef enum logic [1:0] {
    W_WAIT,
    W_SETUP,
    W_STROBE,
    W_HOLD
  } write_phase_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_t;

  // Bus addresses wrap 0xFFFF -> 0x0000 within a burst.
  function automatic address_t next_address(input address_t a);
    return a + 16'd1;
  endfunction

endpackage

// File: rtl/uart_bus_loader_if.sv
// CPU-side bus as seen by the loader: request/grant handshake plus write port.
interface uart_bus_loader_if;
  logic                bus_req_o;
  logic                bus_grant_i;
  mapache64::address_t cpu_address_o;
  mapache64::data_t    data_o;
  logic                wen_no;

  modport master (
    output bus_req_o,
    output cpu_address_o,
    output data_o,
    output wen_no,
    input  bus_grant_i
  );

  modport slave (
    input  bus_req_o,
    input  cpu_address_o,
    input  data_o,
    input  wen_no,
    output bus_grant_i
  );
endinterface

// File: rtl/uart_bus_loader_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling, stop-bit framing check.
//   state        | meaning
//   RX_IDLE      | line idle, waiting for a falling edge
//   RX_START     | half-bit wait, then re-check start bit (glitch filter)
//   RX_DATA      | sampling 8 data bits LSB first
//   RX_STOP      | sampling stop bit
//   RX_WAIT_HIGH | framing error seen, waiting for the line to return high
module uart_rx
  import mapache64::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  rx_i,
  output data_t byte_o,
  output logic  byte_valid_o,
  output logic  frame_err_o
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] FULL_BIT = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF_BIT = TW'(CLKS_PER_BIT / 2 - 1);

  rx_state_t     rx_state;
  logic          rx_meta;
  logic          rx_sync;
  logic          rx_prev;
  logic [TW-1:0] bit_timer;
  logic [2:0]    bit_idx;
  data_t         shreg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta      <= 1'b1;
      rx_sync      <= 1'b1;
      rx_prev      <= 1'b1;
      rx_state     <= RX_IDLE;
      bit_timer    <= '0;
      bit_idx      <= '0;
      shreg        <= '0;
      byte_o       <= '0;
      byte_valid_o <= 1'b0;
      frame_err_o  <= 1'b0;
    end else begin
      rx_meta      <= rx_i;
      rx_sync      <= rx_meta;
      rx_prev      <= rx_sync;
      byte_valid_o <= 1'b0;
      frame_err_o  <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (rx_prev && !rx_sync) begin
            rx_state  <= RX_START;
            bit_timer <= HALF_BIT;
          end
        end
        RX_START: begin
          if (bit_timer == '0) begin
            if (rx_sync) begin
              rx_state <= RX_IDLE;
            end else begin
              rx_state  <= RX_DATA;
              bit_timer <= FULL_BIT;
              bit_idx   <= '0;
            end
          end else begin
            bit_timer <= bit_timer - 1'b1;
          end
        end
        RX_DATA: begin
          if (bit_timer == '0) begin
            shreg     <= {rx_sync, shreg[7:1]};
            bit_timer <= FULL_BIT;
            if (bit_idx == 3'd7) begin
              rx_state <= RX_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            bit_timer <= bit_timer - 1'b1;
          end
        end
        RX_STOP: begin
          if (bit_timer == '0) begin
            if (rx_sync) begin
              byte_o       <= shreg;
              byte_valid_o <= 1'b1;
              rx_state     <= RX_IDLE;
            end else begin
              frame_err_o <= 1'b1;
              rx_state    <= RX_WAIT_HIGH;
            end
          end else begin
            bit_timer <= bit_timer - 1'b1;
          end
        end
        RX_WAIT_HIGH: begin
          if (rx_sync) begin
            rx_state <= RX_IDLE;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_bus_loader.sv
// UART-driven bring-up bus master: parses 'W' write bursts and 'H'/'G' hold
// commands, then drives byte writes onto the console CPU bus once granted.
//   state     | meaning
//   P_IDLE    | waiting for a command byte
//   P_ADDR_HI | next byte is base address [15:8]
//   P_ADDR_LO | next byte is base address [7:0]
//   P_LEN     | next byte is burst length (0 = 256)
//   P_DATA    | next byte is write data
//   P_WRITE   | bus write in progress (WAIT -> SETUP -> STROBE -> HOLD)
module uart_bus_loader
  import mapache64::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int WEN_CYCLES   = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rx_i,
  uart_bus_loader_if.master         bus,
  output logic                      busy_o,
  output logic                      frame_err_o,
  output logic                      overrun_o
);

  localparam int STW = (WEN_CYCLES > 1) ? $clog2(WEN_CYCLES) : 1;

  data_t          rx_byte;
  logic           rx_valid;
  logic           rx_frame_err;

  data_t          hold_data;
  logic           hold_valid;
  parse_state_t   parse_state;
  write_phase_t   write_phase;
  logic           hold_mode;
  address_t       addr_reg;
  logic [8:0]     remaining;
  data_t          wr_data;
  logic [STW-1:0] strobe_timer;
  logic           consume;

  uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk         (clk),
    .rst         (rst),
    .rx_i        (rx_i),
    .byte_o      (rx_byte),
    .byte_valid_o(rx_valid),
    .frame_err_o (rx_frame_err)
  );

  assign consume = hold_valid && (parse_state != P_WRITE);
  assign busy_o  = (parse_state != P_IDLE) || hold_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_data         <= '0;
      hold_valid        <= 1'b0;
      parse_state       <= P_IDLE;
      write_phase       <= W_WAIT;
      hold_mode         <= 1'b0;
      addr_reg          <= '0;
      remaining         <= '0;
      wr_data           <= '0;
      strobe_timer      <= '0;
      frame_err_o       <= 1'b0;
      overrun_o         <= 1'b0;
      bus.bus_req_o     <= 1'b0;
      bus.cpu_address_o <= '0;
      bus.data_o        <= '0;
      bus.wen_no        <= 1'b1;
    end else begin
      if (rx_frame_err) begin
        frame_err_o <= 1'b1;
      end

      // A byte arriving while the slot is still occupied is dropped, even if
      // the slot is being drained this same cycle.
      if (consume) begin
        hold_valid <= 1'b0;
      end
      if (rx_valid) begin
        if (hold_valid) begin
          overrun_o <= 1'b1;
        end else begin
          hold_data  <= rx_byte;
          hold_valid <= 1'b1;
        end
      end

      case (parse_state)
        P_IDLE: begin
          if (consume) begin
            case (hold_data)
              LOADER_CMD_WRITE: begin
                parse_state   <= P_ADDR_HI;
                bus.bus_req_o <= 1'b1;
              end
              LOADER_CMD_HOLD: begin
                hold_mode     <= 1'b1;
                bus.bus_req_o <= 1'b1;
              end
              LOADER_CMD_GO: begin
                hold_mode     <= 1'b0;
                bus.bus_req_o <= 1'b0;
              end
              default: ;
            endcase
          end
        end
        P_ADDR_HI: begin
          if (consume) begin
            addr_reg[15:8] <= hold_data;
            parse_state    <= P_ADDR_LO;
          end
        end
        P_ADDR_LO: begin
          if (consume) begin
            addr_reg[7:0] <= hold_data;
            parse_state   <= P_LEN;
          end
        end
        P_LEN: begin
          if (consume) begin
            remaining   <= (hold_data == 8'h00) ? 9'd256 : {1'b0, hold_data};
            parse_state <= P_DATA;
          end
        end
        P_DATA: begin
          if (consume) begin
            wr_data     <= hold_data;
            write_phase <= W_WAIT;
            parse_state <= P_WRITE;
          end
        end
        P_WRITE: begin
          // Grant is only consulted before SETUP; once started, a write
          // always runs through STROBE and HOLD.
          case (write_phase)
            W_WAIT: begin
              if (bus.bus_grant_i) begin
                bus.cpu_address_o <= addr_reg;
                bus.data_o        <= wr_data;
                write_phase       <= W_SETUP;
              end
            end
            W_SETUP: begin
              bus.wen_no   <= 1'b0;
              strobe_timer <= STW'(WEN_CYCLES - 1);
              write_phase  <= W_STROBE;
            end
            W_STROBE: begin
              if (strobe_timer == '0) begin
                bus.wen_no  <= 1'b1;
                write_phase <= W_HOLD;
              end else begin
                strobe_timer <= strobe_timer - 1'b1;
              end
            end
            W_HOLD: begin
              addr_reg    <= next_address(addr_reg);
              remaining   <= remaining - 9'd1;
              write_phase <= W_WAIT;
              if (remaining == 9'd1) begin
                parse_state   <= P_IDLE;
                bus.bus_req_o <= hold_mode;
              end else begin
                parse_state <= P_DATA;
              end
            end
            default: write_phase <= W_WAIT;
          endcase
        end
        default: parse_state <= P_IDLE;
      endcase
    end
  end

endmodule

// File: doc/uart_bus_loader.md
Name: uart_bus_loader

Overview:
- Bring-up bus master that sits directly upstream of the console top level.
- Receives a byte stream on a UART pin and parses write-burst commands.
- Drives the top-level CPU bus inputs (cpu_address_i, data_i, wen_ni) to load RAM, VRAM and registers without the 65C02.
- Requests bus ownership from board glue, which tri-states the CPU while grant is high.

Parameters:
CLKS_PER_BIT, 16, clk cycles per UART bit; must be >= 8 and even.
WEN_CYCLES, 2, clk cycles wen_no is held low per byte write; must be >= 1.

Ports:
clk  input  1  loader clock
rst  input  1  asynchronous, active-high reset
rx_i  input  1  UART receive line, idle high, asynchronous to clk
bus_grant_i  input  1  board glue has released the CPU bus to this block
bus_req_o  output  1  bus ownership request
cpu_address_o  output  mapache64::address_t  bus address driven to top
data_o  output  mapache64::data_t  bus write data
wen_no  output  1  active-low write strobe
busy_o  output  1  parser not in IDLE, or a write is in flight
frame_err_o  output  1  sticky: a stop bit sampled low
overrun_o  output  1  sticky: a byte completed while the holding register was full

Behaviour:
- Reset values: bus_req_o=0, cpu_address_o=0, data_o=0, wen_no=1, busy_o=0, frame_err_o=0, overrun_o=0. Both stickies clear only on rst. rst mid-burst aborts immediately, with wen_no=1 on the same edge.
- RX path:
  - rx_i passes through a 2-flop synchronizer.
  - A falling edge in RX_IDLE starts a bit counter. At CLKS_PER_BIT/2 the start bit is re-checked; if high, it was a glitch and the receiver returns to RX_IDLE.
  - 8 data bits are then sampled LSB first at CLKS_PER_BIT intervals, followed by the stop bit.
  - Stop bit = 0: set frame_err_o, discard the byte, and wait for rx high before returning to RX_IDLE.
  - A good byte loads a 1-entry holding register with a valid flag. If valid is already set, drop the new byte and set overrun_o.
- Parser FSM consumes the holding register one byte per cycle, and only when it is not in WRITE.
  - IDLE:
    - 0x57 'W' -> ADDR_HI.
    - 0x48 'H' sets hold.
    - 0x47 'G' clears hold.
    - Any other byte is ignored.
  - ADDR_HI, ADDR_LO: load the 16-bit base address, big-endian.
  - LEN: load an 8-bit count; 0 means 256. Next state DATA.
  - DATA: on a byte -> WRITE.
  - WRITE, single byte write sequence:
    - Wait until bus_grant_i=1.
    - SETUP: 1 clk, address and data driven, wen_no=1.
    - STROBE: WEN_CYCLES clks, wen_no=0.
    - HOLD: 1 clk, wen_no=1, address and data still stable.
    - Then address+1 (16-bit wrap 0xFFFF->0x0000) and remaining-1. Go to DATA if remaining>0, else IDLE.
- Write cadence: one byte write is WEN_CYCLES+2 clks after grant, well under one UART byte (10*CLKS_PER_BIT).
- Bus request:
  - bus_req_o = hold OR parser in {ADDR_HI, ADDR_LO, LEN, DATA, WRITE}. It is registered, so it rises 1 clk after 'W' is consumed.
  - bus_req_o falls 1 clk after HOLD of the last byte, unless hold=1.
  - Grant dropping mid-WRITE is a board fault: STROBE and HOLD still complete, and the next byte waits for grant again.
- Stall: while grant is low and a byte sits in WRITE, further RX bytes fill the holding register; one more byte then causes overrun.
- cpu_address_o and data_o hold their last values outside WRITE; wen_no=1 everywhere except STROBE.
- busy_o = parser != IDLE OR holding register valid.

Decomposition:
- Shared package mapache64: add the loader command constants (LOADER_CMD_WRITE=8'h57, LOADER_CMD_HOLD=8'h48, LOADER_CMD_GO=8'h47). Reuse address_t and data_t.
- One sub-module: uart_rx (synchronizer, bit timing, framing), outputs byte+strobe+frame_err. Parser, holding register and bus sequencer stay in uart_bus_loader.

Test Plan:
- Reset: assert rst mid-STROBE -> wen_no=1 and bus_req_o=0 the same edge; all outputs at reset values.
- Burst: grant tied high, send 57 40 10 03 AA BB CC -> three writes at 0x4010/0x4011/0x4012 with data AA/BB/CC. Each write has wen_no low for exactly 2 clks; bus_req_o is low again 1 clk after the last HOLD.
- Wrap and length: send 57 FF FF 02 11 22 -> writes at 0xFFFF then 0x0000. Send LEN=00 with 256 bytes -> exactly 256 strobes.
- Hold: send 48, then 'W' burst of 1 byte, then 47 -> bus_req_o stays high from 48 until 1 clk after 47 is consumed, including across the burst.
- Grant stall: grant low, send 57 50 00 03 01 02 03 -> byte 01 waits in WRITE, 02 fills the holding register, 03 sets overrun_o=1. Raising grant writes 01 then 02.
- Framing: byte with stop bit 0 -> frame_err_o=1, no parser state change. A 1/4-bit low glitch on rx_i -> no byte received.
